// File: rtl/fifo_in_skew_pkg.sv
// Shared definitions for the input skew buffer and the output deskew stage:
// array geometry, host command encodings and the skew FSM states.
package fifo_in_skew_pkg;

    localparam int N      = 16;
    localparam int W      = 8;
    localparam int BEATS  = 4;
    localparam int WORD_W = 32;
    localparam int COL_W  = $clog2(BEATS);
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_READ  = 2'b10,
        CMD_DRAIN = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Byte j of an assembled vector; byte 0 is the top byte of the col-0 beat.
    function automatic logic [W-1:0] vec_lane(input logic [N*W-1:0] vec, input int j);
        return vec[(N-1-j)*W +: W];
    endfunction

endpackage

// File: rtl/fifo_in_skew_if.sv
// Host-side write bus and array-side outputs of the input skew buffer.
interface fifo_in_skew_if;
    import fifo_in_skew_pkg::*;

    logic [WORD_W-1:0] input0;
    logic [COL_W-1:0]  col;
    logic [1:0]        command;
    logic [N*W-1:0]    out_data;
    logic [N-1:0]      lane_valid;
    logic              step;
    logic              busy;

    modport master (
        output input0, col, command,
        input  out_data, lane_valid, step, busy
    );

    modport slave (
        input  input0, col, command,
        output out_data, lane_valid, step, busy
    );

endinterface

// File: rtl/skew_lane.sv
// Shift-enabled delay chain of DEPTH W-bit registers; dout is the last stage.
module skew_lane #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] chain_r [DEPTH];

    // Delay chain: advances one place per push, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) chain_r[i] <= {W{1'b0}};
        end else if (shift_en) begin
            chain_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) chain_r[i] <= chain_r[i-1];
        end
    end

    assign dout = chain_r[DEPTH-1];

endmodule

// File: rtl/fifo_in_skew.sv
// Input skew buffer: stages three host beats, pushes the assembled vector into
// triangular delay lines on the col-3 beat, and flushes the skew tail on DRAIN.
module fifo_in_skew
    import fifo_in_skew_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fifo_in_skew_if.slave bus
);

    state_e            state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic              push_s, drain_push_s, stage_we_s;
    logic [WORD_W-1:0] stage_r [BEATS-1];
    logic [N*W-1:0]    vec_s;
    logic [W-1:0]      lane_in_s  [N];
    logic [W-1:0]      lane_out_s [N];
    logic [N-1:0]      valid_r;
    logic              step_r, busy_r;

    // col-3 bytes bypass staging so the push happens on the same beat.
    assign vec_s = {stage_r[0], stage_r[1], stage_r[2], bus.input0};

    // FSM next state, push qualification and drain counter.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        push_s       = 1'b0;
        drain_push_s = 1'b0;
        stage_we_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.command == CMD_LOAD) begin
                    if (bus.col == 2'd3) push_s = 1'b1;
                    else                 stage_we_s = 1'b1;
                end else if (bus.command == CMD_DRAIN) begin
                    state_next_s = ST_DRAIN;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                push_s       = 1'b1;
                drain_push_s = 1'b1;
                cnt_next_s   = (cnt_r == DRAIN_LAST) ? cnt_r : cnt_r + 4'd1;
                if (cnt_r >= DRAIN_LAST - 4'd1) state_next_s = ST_IDLE;
                else                            state_next_s = ST_DRAIN;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Per-lane input byte: zeros while draining, else the assembled vector.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            lane_in_s[j] = drain_push_s ? {W{1'b0}} : vec_lane(vec_s, j);
        end
    end

    // FSM state, drain counter, valid chain and step/busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            valid_r <= {N{1'b0}};
            step_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            step_r  <= push_s;
            busy_r  <= (state_next_s == ST_DRAIN);
            if (push_s) valid_r <= {valid_r[N-2:0], ~drain_push_s};
        end
    end

    // Staging registers for beats 0..2; a repeated beat overwrites its slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < BEATS-1; b++) stage_r[b] <= {WORD_W{1'b0}};
        end else if (stage_we_s) begin
            case (bus.col)
                2'd0:    stage_r[0] <= bus.input0;
                2'd1:    stage_r[1] <= bus.input0;
                2'd2:    stage_r[2] <= bus.input0;
                default: stage_r[0] <= stage_r[0];
            endcase
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        skew_lane #(
            .DEPTH (j + 1),
            .W     (W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .shift_en (push_s),
            .din      (lane_in_s[j]),
            .dout     (lane_out_s[j])
        );
    end

    // Pack lane outputs onto the array-row bus.
    always_comb begin
        bus.out_data = {(N*W){1'b0}};
        for (int j = 0; j < N; j++) bus.out_data[j*W +: W] = lane_out_s[j];
    end

    assign bus.lane_valid = valid_r;
    assign bus.step       = step_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_fifo_in_skew.sv
// Scoreboard bench for fifo_in_skew: stimulus enqueues the expected array-side
// view per push from a push-history model; a negedge monitor checks every step.
module tb_fifo_in_skew;
    import fifo_in_skew_pkg::*;

    localparam int NW = N * W;

    typedef struct packed {
        logic [NW-1:0] data;
        logic [N-1:0]  valid;
        logic          busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    fifo_in_skew_if bus();

    fifo_in_skew dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [NW-1:0] hist[$];
    logic          hist_v[$];
    logic [31:0]   stg[3];
    logic [NW-1:0] exp_out;
    logic [N-1:0]  exp_valid;

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        hist_v.delete();
        sb.delete();
        for (int i = 0; i < 3; i++) stg[i] = 32'h0;
        exp_out   = {NW{1'b0}};
        exp_valid = {N{1'b0}};
    endfunction

    // Lane j shows byte j of the vector pushed j pushes ago (lane-ordered model vectors).
    function automatic void model_push(input logic [NW-1:0] vec, input logic v, input logic b);
        hist.push_front(vec);
        hist_v.push_front(v);
        exp_out   = {NW{1'b0}};
        exp_valid = {N{1'b0}};
        for (int j = 0; j < N; j++) begin
            if (j < hist.size()) begin
                exp_out[j*W +: W] = hist[j][j*W +: W];
                exp_valid[j]      = hist_v[j];
            end
        end
        sb.push_back({exp_out, exp_valid, b});
    endfunction

    function automatic logic [NW-1:0] assemble(input logic [31:0] b0, input logic [31:0] b1,
                                               input logic [31:0] b2, input logic [31:0] b3);
        logic [31:0]   bw[4];
        logic [NW-1:0] r;
        bw[0] = b0; bw[1] = b1; bw[2] = b2; bw[3] = b3;
        r = {NW{1'b0}};
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                r[(4*c+k)*W +: W] = bw[c][31-8*k -: 8];
        return r;
    endfunction

    function automatic logic [31:0] beat_word(input int v, input int c);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[31-8*k -: 8] = 8'(16*v + 4*c + k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] cmd, input logic [1:0] c, input logic [31:0] d);
        bus.command = cmd;
        bus.col     = c;
        bus.input0  = d;
        if (cmd == CMD_LOAD) begin
            case (c)
                2'd0:    stg[0] = d;
                2'd1:    stg[1] = d;
                2'd2:    stg[2] = d;
                default: model_push(assemble(stg[0], stg[1], stg[2], d), 1'b1, 1'b0);
            endcase
        end
        tick();
        bus.command = CMD_IDLE;
    endtask

    task automatic load_vec(input int v);
        for (int c = 0; c < 4; c++) drive(CMD_LOAD, 2'(c), beat_word(v, c));
    endtask

    // Issue DRAIN and follow it to the final step; optionally hammer it with commands.
    task automatic do_drain(input bit inject);
        int busy_cnt = 0;
        int step_cnt = 0;
        bit done = 1'b0;
        bus.command = CMD_DRAIN;
        for (int i = 0; i < N-1; i++) model_push({NW{1'b0}}, 1'b0, (i != N-2));
        tick();
        bus.command = CMD_IDLE;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.step === 1'b1) step_cnt++;
        for (int k = 0; k < 40 && !done; k++) begin
            if (inject) begin
                case (k % 3)
                    0:       begin bus.command = CMD_LOAD;  bus.col = 2'd3; bus.input0 = 32'hFFEEDDCC; end
                    1:       begin bus.command = CMD_DRAIN; bus.col = 2'd0; bus.input0 = 32'h0; end
                    default: begin bus.command = CMD_LOAD;  bus.col = 2'd0; bus.input0 = 32'h5A5A5A5A; end
                endcase
            end
            tick();
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.step === 1'b1) step_cnt++;
            if (bus.step === 1'b1 && bus.busy === 1'b0) done = 1'b1;
        end
        bus.command = CMD_IDLE;
        chk("drain_completed", NW'(done), NW'(1));
        chk("drain_busy_cycles", NW'(busy_cnt), NW'(15));
        chk("drain_step_pulses", NW'(step_cnt), NW'(15));
    endtask

    // Monitor: every step pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.step === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_step actual=step required=no_step t=%0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_out_data", bus.out_data, mon_e.data);
                chk("sb_lane_valid", NW'(bus.lane_valid), NW'(mon_e.valid));
                chk("sb_busy", NW'(bus.busy), NW'(mon_e.busy));
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int step_seen;
        bus.command = CMD_IDLE;
        bus.col     = 2'd0;
        bus.input0  = 32'h0;
        reset       = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_data", bus.out_data, {NW{1'b0}});
        chk("rst_lane_valid", NW'(bus.lane_valid), NW'(0));
        chk("rst_step", NW'(bus.step), NW'(0));
        chk("rst_busy", NW'(bus.busy), NW'(0));
        reset = 1'b0;
        tick();

        // Reset asserted mid-drain clears everything in the same cycle.
        load_vec(0);
        bus.command = CMD_DRAIN;
        tick();
        bus.command = CMD_IDLE;
        model_push({NW{1'b0}}, 1'b0, 1'b1);
        model_push({NW{1'b0}}, 1'b0, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        #1;
        chk("abort_out_data", bus.out_data, {NW{1'b0}});
        chk("abort_lane_valid", NW'(bus.lane_valid), NW'(0));
        chk("abort_busy", NW'(bus.busy), NW'(0));
        chk("abort_step", NW'(bus.step), NW'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("post_abort_busy", NW'(bus.busy), NW'(0));
        chk("post_abort_step", NW'(bus.step), NW'(0));

        // Single vector: lane0=00, valid=0001, all other lanes still zero.
        load_vec(0);
        chk("t2_out_data", bus.out_data, {NW{1'b0}});
        chk("t2_lane_valid", NW'(bus.lane_valid), NW'(16'h0001));
        chk("t2_step", NW'(bus.step), NW'(1));

        // Drain that single vector out to lane 15.
        do_drain(1'b0);
        chk("t5_lane15", NW'(bus.out_data[15*W +: W]), NW'(8'h0F));
        chk("t5_lane_valid", NW'(bus.lane_valid), NW'(16'h8000));
        tick();
        chk("t5_busy_low", NW'(bus.busy), NW'(0));
        chk("t5_no_extra_step", NW'(bus.step), NW'(0));

        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        tick();

        // Four vectors with idle gaps; lane3 reaches byte 3 of the first one.
        load_vec(0);
        load_vec(1);
        tick();
        tick();
        chk("t3_idle_hold", bus.out_data, exp_out);
        load_vec(2);
        tick();
        load_vec(3);
        chk("t3_lane0", NW'(bus.out_data[0*W +: W]), NW'(8'h30));
        chk("t3_lane1", NW'(bus.out_data[1*W +: W]), NW'(8'h21));
        chk("t3_lane2", NW'(bus.out_data[2*W +: W]), NW'(8'h12));
        chk("t3_lane3", NW'(bus.out_data[3*W +: W]), NW'(8'h03));
        chk("t3_lane_valid", NW'(bus.lane_valid), NW'(16'h000F));

        // Partial vector plus READ commands: nothing moves.
        drive(CMD_LOAD, 2'd0, 32'hAAAAAAAA);
        drive(CMD_LOAD, 2'd1, 32'h11111111);
        drive(CMD_LOAD, 2'd1, 32'hBBBBBBBB);
        drive(CMD_LOAD, 2'd2, 32'hCCCCCCCC);
        step_seen = 0;
        bus.command = CMD_READ;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.step !== 1'b0) step_seen++;
        end
        bus.command = CMD_IDLE;
        chk("t4_no_step", NW'(step_seen), NW'(0));
        chk("t4_out_hold", bus.out_data, exp_out);
        chk("t4_valid_hold", NW'(bus.lane_valid), NW'(exp_valid));

        // Drain while commands are thrown at it; staging must survive.
        do_drain(1'b1);
        tick();
        chk("t6_busy_low", NW'(bus.busy), NW'(0));
        chk("t6_no_extra_step", NW'(bus.step), NW'(0));
        drive(CMD_LOAD, 2'd3, 32'hDDDDDDDD);
        chk("t6_stage0_kept", NW'(bus.out_data[0*W +: W]), NW'(8'hAA));
        chk("t6_lane0_valid", NW'(bus.lane_valid[0]), NW'(1));

        tick();
        tick();
        chk("sb_empty", NW'(sb.size()), NW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
